// File: rtl/commit_mem_read_refillseq.sv
// Refill sequencer: one line refill as an 8-beat wrapping read burst,
// forwarding each returned word with its offset into the update buffer.
//
// Ports:
//   clk, reset          clock, async active-high reset
//   req_valid/ready     refill request handshake, req_addr = miss address
//   m_ar*               burst address channel (m_araddr word aligned)
//   m_r*                read data channel (m_rlast, m_rerr per beat)
//   wea, dina_addr/data update-buffer write port, s_full = backpressure
//   busy, done, err     status to commit logic (err valid with done)
module commit_mem_read_refillseq #(
  parameter bit WRAP_EN = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [31:0] m_araddr,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [31:0] m_rdata,
  input  logic        m_rlast,
  input  logic        m_rerr,
  output logic        wea,
  output logic [31:0] dina_addr,
  output logic [31:0] dina_data,
  input  logic        s_full,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [26:0] line;
  logic [2:0]  off;
  logic [3:0]  cnt;
  logic        errf;

  logic acc;
  logic last_cnt;
  logic term;
  logic beat_err;

  logic unused_addr_lsb;
  assign unused_addr_lsb = ^req_addr[1:0];

  assign acc      = (state == DATA) & m_rvalid & ~s_full;
  assign last_cnt = (cnt == 4'd7);
  assign term     = acc & (m_rlast | last_cnt);
  // rlast must coincide exactly with the 8th beat
  assign beat_err = m_rerr | (m_rlast ^ last_cnt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    req_ready = 1'b0;
    m_arvalid = 1'b0;
    m_araddr  = 32'd0;
    m_rready  = 1'b0;
    wea       = 1'b0;
    dina_addr = 32'd0;
    dina_data = 32'd0;
    busy      = 1'b1;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) state_nx = ADDR;
      end
      ADDR: begin
        m_arvalid = 1'b1;
        m_araddr  = {line, off, 2'b00};
        if (m_arready) state_nx = DATA;
      end
      DATA: begin
        m_rready = ~s_full;
        if (acc) begin
          wea       = 1'b1;
          dina_addr = {line, off, 2'b00};
          dina_data = m_rdata;
        end
        if (term) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        err      = errf;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line <= 27'd0;
      off  <= 3'd0;
      cnt  <= 4'd0;
      errf <= 1'b0;
    end else begin
      if (state == IDLE && req_valid) begin
        line <= req_addr[31:5];
        off  <= WRAP_EN ? req_addr[4:2] : 3'd0;
        cnt  <= 4'd0;
        errf <= 1'b0;
      end else if (acc) begin
        off <= off + 3'd1;
        cnt <= cnt + 4'd1;
        if (beat_err) errf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_commit_mem_read_refillseq.sv
// Bench for commit_mem_read_refillseq: wrap and non-wrap instances
// share stimulus and are checked against a transaction-level model.
module tb_commit_mem_read_refillseq;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        m_arready;
  logic        m_rvalid;
  logic [31:0] m_rdata;
  logic        m_rlast;
  logic        m_rerr;
  logic        s_full;

  logic        req_ready_w, m_arvalid_w, m_rready_w, wea_w;
  logic        busy_w, done_w, err_w;
  logic [31:0] m_araddr_w, dina_addr_w, dina_data_w;
  logic        req_ready_n, m_arvalid_n, m_rready_n, wea_n;
  logic        busy_n, done_n, err_n;
  logic [31:0] m_araddr_n, dina_addr_n, dina_data_n;

  commit_mem_read_refillseq #(.WRAP_EN(1'b1)) u_w (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_w), .req_addr(req_addr),
    .m_arvalid(m_arvalid_w), .m_arready(m_arready), .m_araddr(m_araddr_w),
    .m_rvalid(m_rvalid), .m_rready(m_rready_w), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rerr(m_rerr),
    .wea(wea_w), .dina_addr(dina_addr_w), .dina_data(dina_data_w),
    .s_full(s_full), .busy(busy_w), .done(done_w), .err(err_w)
  );

  commit_mem_read_refillseq #(.WRAP_EN(1'b0)) u_n (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready_n), .req_addr(req_addr),
    .m_arvalid(m_arvalid_n), .m_arready(m_arready), .m_araddr(m_araddr_n),
    .m_rvalid(m_rvalid), .m_rready(m_rready_n), .m_rdata(m_rdata),
    .m_rlast(m_rlast), .m_rerr(m_rerr),
    .wea(wea_n), .dina_addr(dina_addr_n), .dina_data(dina_data_n),
    .s_full(s_full), .busy(busy_n), .done(done_n), .err(err_n)
  );

  always #5 clk = ~clk;

  int nchk = 0;
  int npass = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    nchk++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Model: refill in flight, address phase pending, done due next,
  // beats taken so far, error seen, captured line and start offset.
  bit          mb, ma, mdd, merr;
  int          mbeats;
  logic [26:0] mline;
  logic [2:0]  mst;

  // Observation logs for the directed literal checks
  logic [31:0] wlog[$];
  logic [31:0] nlog[$];
  logic [31:0] ar_w, ar_n;
  int          ndone, req_cyc, done_cyc, wfirst, wlast;
  logic        last_err;

  task automatic clear_logs();
    wlog.delete();
    nlog.delete();
    ndone = 0;
    wfirst = -1;
    wlast = -1;
    ar_w = 32'hx;
    ar_n = 32'hx;
  endtask

  task automatic cmp_inst(
    string t, logic [2:0] st,
    logic rr, logic av, logic [31:0] aa, logic rdy, logic we,
    logic [31:0] da, logic [31:0] dd, logic bs, logic dn, logic er
  );
    bit          indata, acc;
    logic [2:0]  o;
    indata = mb & !ma & !mdd;
    acc    = indata & m_rvalid & !s_full;
    o      = st + 3'(mbeats);
    chk({t, ".req_ready"}, rr, !mb);
    chk({t, ".busy"}, bs, mb);
    chk({t, ".m_arvalid"}, av, ma);
    chk({t, ".m_araddr"}, aa, ma ? {mline, st, 2'b00} : 32'd0);
    chk({t, ".m_rready"}, rdy, indata & !s_full);
    chk({t, ".wea"}, we, acc);
    chk({t, ".dina_addr"}, da, acc ? {mline, o, 2'b00} : 32'd0);
    if (acc) chk({t, ".dina_data"}, dd, m_rdata);
    chk({t, ".done"}, dn, mdd);
    chk({t, ".err"}, er, mdd & merr);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      mb = 0; ma = 0; mdd = 0; merr = 0; mbeats = 0;
      mline = '0; mst = '0;
    end
    cmp_inst("w", mst, req_ready_w, m_arvalid_w, m_araddr_w, m_rready_w,
             wea_w, dina_addr_w, dina_data_w, busy_w, done_w, err_w);
    cmp_inst("n", 3'd0, req_ready_n, m_arvalid_n, m_araddr_n, m_rready_n,
             wea_n, dina_addr_n, dina_data_n, busy_n, done_n, err_n);
    if (wea_w) begin
      wlog.push_back(dina_addr_w);
      if (wfirst < 0) wfirst = cyc;
      wlast = cyc;
    end
    if (wea_n) nlog.push_back(dina_addr_n);
    if (m_arvalid_w) ar_w = m_araddr_w;
    if (m_arvalid_n) ar_n = m_araddr_n;
    if (done_w) begin
      ndone++;
      done_cyc = cyc;
      last_err = err_w;
    end
    if (!reset && req_valid && req_ready_w) req_cyc = cyc;
    if (!reset) begin
      if (mdd) begin
        mb = 0; mdd = 0;
      end else if (!mb) begin
        if (req_valid) begin
          mb = 1; ma = 1; mbeats = 0; merr = 0;
          mline = req_addr[31:5];
          mst = req_addr[4:2];
        end
      end else if (ma) begin
        if (m_arready) ma = 0;
      end else if (m_rvalid && !s_full) begin
        mbeats++;
        if (m_rerr) merr = 1;
        if (m_rlast || mbeats == 8) begin
          mdd = 1;
          if (m_rlast != (mbeats == 8)) merr = 1;
        end
      end
    end
  end

  task automatic idle_inputs();
    req_valid = 0; m_arready = 0; m_rvalid = 0;
    m_rlast = 0; m_rerr = 0; s_full = 0;
  endtask

  task automatic check_reset_outs(string t);
    chk({t, ".req_ready"}, req_ready_w, 1'b1);
    chk({t, ".busy"}, busy_w | busy_n, 1'b0);
    chk({t, ".arvalid"}, m_arvalid_w | m_arvalid_n, 1'b0);
    chk({t, ".rready"}, m_rready_w | m_rready_n, 1'b0);
    chk({t, ".wea"}, wea_w | wea_n, 1'b0);
    chk({t, ".done_err"}, {done_w, err_w, done_n, err_n}, 4'd0);
    chk({t, ".araddr"}, m_araddr_w | m_araddr_n, 32'd0);
    chk({t, ".dina_addr"}, dina_addr_w | dina_addr_n, 32'd0);
  endtask

  // rlast_at: beat number carrying m_rlast (0 = never). fmode: 0 no
  // backpressure, 1 four-cycle stall at beat 3, 2 random. rnd: random
  // arready/rvalid gaps. abort_at: reset after that many beats.
  task automatic run(logic [31:0] addr, int rlast_at, logic [7:0] emask,
                     int fmode, bit rnd, int abort_at);
    bit ok, hs, pres, fin;
    int bidx, fc;
    @(posedge clk); #1;
    req_valid = 1;
    req_addr = addr;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk); ok = req_ready_w;
      @(posedge clk); #1;
    end
    if (!ok) chk("timeout.req", 0, 1);
    req_valid = rnd ? 1'($urandom) : 1'b0;
    req_addr = $urandom;
    hs = 0;
    for (int i = 0; i < 50 && !hs; i++) begin
      m_arready = rnd ? ($urandom % 3 != 0) : 1'b1;
      @(negedge clk); hs = m_arvalid_w & m_arready;
      @(posedge clk); #1;
      req_valid = rnd ? 1'($urandom) : 1'b0;
    end
    if (!hs) chk("timeout.ar", 0, 1);
    m_arready = 0;
    bidx = 0; pres = 0; fc = 0; fin = 0;
    for (int i = 0; i < 300 && !fin; i++) begin
      case (fmode)
        1: begin s_full = (bidx == 2 && fc < 4); if (s_full) fc++; end
        2: s_full = ($urandom % 4 == 0);
        default: s_full = 0;
      endcase
      if (!pres && bidx < 8 && (!rnd || $urandom % 4 != 0)) begin
        pres = 1;
        m_rvalid = 1;
        m_rdata = $urandom;
        m_rlast = (bidx + 1 == rlast_at);
        m_rerr = emask[bidx];
      end
      @(negedge clk);
      if (m_rvalid && m_rready_w) begin bidx++; pres = 0; end
      fin = done_w;
      if (abort_at != 0 && bidx == abort_at) begin
        #1 reset = 1;
        #1 check_reset_outs("abort");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 reset = 0;
        return;
      end
      @(posedge clk); #1;
      if (!pres) begin m_rvalid = 0; m_rlast = 0; m_rerr = 0; end
      req_valid = (rnd && !fin) ? 1'($urandom) : 1'b0;
    end
    if (!fin) chk("timeout.data", 0, 1);
    idle_inputs();
  endtask

  initial begin
    reset = 1;
    req_addr = 0;
    m_rdata = 0;
    idle_inputs();
    clear_logs();
    #1 check_reset_outs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 0;

    clear_logs();
    run(32'h0000_1014, 8, 8'h00, 0, 0, 0);
    chk("basic.araddr_w", ar_w, 32'h1014);
    chk("basic.araddr_n", ar_n, 32'h1000);
    chk("basic.nwea", wlog.size(), 8);
    chk("basic.w0", wlog[0], 32'h1014);
    chk("basic.w1", wlog[1], 32'h1018);
    chk("basic.w2", wlog[2], 32'h101C);
    chk("basic.w3", wlog[3], 32'h1000);
    chk("basic.w7", wlog[7], 32'h1010);
    chk("basic.n0", nlog[0], 32'h1000);
    chk("basic.n7", nlog[7], 32'h101C);
    chk("basic.burst_len", wlast - wfirst, 7);
    // request cycle counts as cycle 1, done lands on cycle 11
    chk("basic.latency", done_cyc - req_cyc, 10);
    chk("basic.err", last_err, 1'b0);

    clear_logs();
    run(32'h0000_2008, 8, 8'h00, 1, 0, 0);
    chk("stall.nwea", wlog.size(), 8);
    chk("stall.burst_len", wlast - wfirst, 11);
    chk("stall.w7", wlog[7], 32'h2004);
    chk("stall.err", last_err, 1'b0);

    clear_logs();
    run(32'h0000_3000, 5, 8'h00, 0, 0, 0);
    chk("rlast.nwea", wlog.size(), 5);
    chk("rlast.done_gap", done_cyc - wlast, 1);
    chk("rlast.err", last_err, 1'b1);

    clear_logs();
    run(32'h0000_4000, 8, 8'h02, 0, 0, 0);
    chk("rerr.nwea", wlog.size(), 8);
    chk("rerr.err", last_err, 1'b1);
    clear_logs();
    run(32'h0000_4020, 8, 8'h00, 0, 0, 0);
    chk("clean.err", last_err, 1'b0);

    clear_logs();
    run(32'h0000_4010, 8, 8'h00, 0, 0, 4);
    chk("abort.ndone", ndone, 0);
    clear_logs();
    run(32'h0000_5010, 8, 8'h00, 0, 0, 0);
    chk("after_reset.ndone", ndone, 1);
    chk("after_reset.nwea", wlog.size(), 8);
    chk("after_reset.err", last_err, 1'b0);

    for (int k = 0; k < 30; k++) begin
      int rl;
      logic [7:0] em;
      rl = ($urandom % 3 == 0) ? int'($urandom % 9) : 8;
      em = ($urandom % 4 == 0) ? 8'(1 << ($urandom % 8)) : 8'h00;
      clear_logs();
      run($urandom, rl, em, 2, 1, 0);
      chk("rand.ndone", ndone, 1);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
